// File: rtl/fpu_result_collector.sv
// Collects FPU results at the fixed pipeline latency, buffers them in a small
// show-ahead FIFO and meters issue credit so that no result can be lost.
module fpu_result_collector #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [2:0]       issue_op,
  input  logic [31:0]      out,
  input  logic             inf,
  input  logic             snan,
  input  logic             qnan,
  input  logic             ine,
  input  logic             overflow,
  input  logic             underflow,
  input  logic             zero,
  input  logic             div_by_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [7:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [2:0]       rsp_op,
  output logic             err_drop
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] pipe_valid;
  logic [TAG_W-1:0]   pipe_tag [LATENCY];
  logic [2:0]         pipe_op  [LATENCY];

  logic [31:0]        mem_data  [DEPTH];
  logic [7:0]         mem_flags [DEPTH];
  logic [TAG_W-1:0]   mem_tag   [DEPTH];
  logic [2:0]         mem_op    [DEPTH];

  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;
  logic [PW:0]        occ;
  logic [CW-1:0]      inflight;
  logic [7:0]         flags;
  logic               accept;
  logic               push;
  logic               pop;

  assign flags  = {div_by_zero, zero, underflow, overflow, ine, qnan, snan, inf};
  assign accept = issue_valid & issue_ready;
  assign push   = pipe_valid[LATENCY-1];
  assign pop    = rsp_valid & rsp_ready;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      inflight = inflight + CW'(pipe_valid[i]);
    end
  end

  // Credit counts both results still in the FPU and results parked in the
  // FIFO, so a slot is reserved at issue time and freed only on a pop.
  assign issue_ready = (inflight + CW'(occ)) < CW'(DEPTH);

  assign rsp_valid = (occ != '0);
  assign rsp_data  = mem_data[rptr];
  assign rsp_flags = mem_flags[rptr];
  assign rsp_tag   = mem_tag[rptr];
  assign rsp_op    = mem_op[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_tag[i] <= '0;
        pipe_op[i]  <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_tag[0]   <= issue_tag;
      pipe_op[0]    <= issue_op;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_tag[i]   <= pipe_tag[i-1];
        pipe_op[i]    <= pipe_op[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i]  <= '0;
        mem_flags[i] <= '0;
        mem_tag[i]   <= '0;
        mem_op[i]    <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wptr]  <= out;
        mem_flags[wptr] <= flags;
        mem_tag[wptr]   <= pipe_tag[LATENCY-1];
        mem_op[wptr]    <= pipe_op[LATENCY-1];
        wptr            <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop <= 1'b0;
    end else if (issue_valid && !issue_ready) begin
      err_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector; a small delay-line FPU stand-in
// returns each issued result word LATENCY clocks after issue.
module tb_fpu_result_collector;

  localparam int unsigned LAT = 4;
  localparam int unsigned DEP = 4;
  localparam int unsigned TW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_valid;
  logic          issue_ready;
  logic [TW-1:0] issue_tag;
  logic [2:0]    issue_op;
  logic [31:0]   out;
  logic          inf, snan, qnan, ine, overflow, underflow, zero, div_by_zero;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [7:0]    rsp_flags;
  logic [TW-1:0] rsp_tag;
  logic [2:0]    rsp_op;
  logic          err_drop;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] drv_res;
  logic [7:0]  drv_flags;
  logic [31:0] m_res   [LAT];
  logic [7:0]  m_flags [LAT];

  always #5 clk = ~clk;

  // FPU stand-in: not reset, so stale words keep flowing after a reset.
  always @(posedge clk) begin
    m_res[0]   <= drv_res;
    m_flags[0] <= drv_flags;
    for (int i = 1; i < LAT; i++) begin
      m_res[i]   <= m_res[i-1];
      m_flags[i] <= m_flags[i-1];
    end
  end

  assign out         = m_res[LAT-1];
  assign inf         = m_flags[LAT-1][0];
  assign snan        = m_flags[LAT-1][1];
  assign qnan        = m_flags[LAT-1][2];
  assign ine         = m_flags[LAT-1][3];
  assign overflow    = m_flags[LAT-1][4];
  assign underflow   = m_flags[LAT-1][5];
  assign zero        = m_flags[LAT-1][6];
  assign div_by_zero = m_flags[LAT-1][7];

  fpu_result_collector #(.LATENCY(LAT), .DEPTH(DEP), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_tag(issue_tag), .issue_op(issue_op),
    .out(out), .inf(inf), .snan(snan), .qnan(qnan), .ine(ine),
    .overflow(overflow), .underflow(underflow), .zero(zero), .div_by_zero(div_by_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_op(rsp_op), .err_drop(err_drop)
  );

  always @(posedge clk) begin
    if (rst_n && dut.push && !dut.pop)
      assert (dut.occ != DEP) else $error("result FIFO written while full");
  end

  task automatic drive(input logic v, input logic [TW-1:0] tag, input logic [2:0] op,
                       input logic [31:0] res, input logic [7:0] fl);
    issue_valid = v;
    issue_tag   = tag;
    issue_op    = op;
    drv_res     = res;
    drv_flags   = fl;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 32'hDEAD_BEEF, 8'hFF);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_chk++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %b want 1", issue_ready); else n_pass++;
    n_chk++; if (err_drop !== 1'b0) $display("FAIL reset_err_drop: got %b want 0", err_drop); else n_pass++;
    n_chk++; if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data); else n_pass++;
    n_chk++; if (rsp_flags !== 8'h0) $display("FAIL reset_rsp_flags: got %h want 0", rsp_flags); else n_pass++;
    n_chk++; if (rsp_tag !== 4'h0 || rsp_op !== 3'h0) $display("FAIL reset_tag_op: got %h/%h want 0/0", rsp_tag, rsp_op); else n_pass++;
  endtask

  task automatic test_single(input string name, input logic [TW-1:0] tag, input logic [2:0] op,
                             input logic [31:0] res, input logic [7:0] fl);
    int early;
    early = 0;
    rsp_ready = 1'b1;
    drive(1'b1, tag, op, res, fl);
    @(negedge clk);
    idle();
    for (int c = 0; c < LAT; c++) begin
      if (rsp_valid !== 1'b0) early++;
      @(negedge clk);
    end
    n_chk++; if (early != 0 || rsp_valid !== 1'b1)
      $display("FAIL %s_latency: early=%0d valid=%b want early=0 valid=1", name, early, rsp_valid); else n_pass++;
    n_chk++; if (rsp_data !== res) $display("FAIL %s_data: got %h want %h", name, rsp_data, res); else n_pass++;
    n_chk++; if (rsp_flags !== fl) $display("FAIL %s_flags: got %h want %h", name, rsp_flags, fl); else n_pass++;
    n_chk++; if (rsp_tag !== tag || rsp_op !== op)
      $display("FAIL %s_tag_op: got %h/%h want %h/%h", name, rsp_tag, rsp_op, tag, op); else n_pass++;
    @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL %s_popped: got %b want 0", name, rsp_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n_iss, n_rx, bad;
    logic [TW-1:0] rx_tag [8];
    logic [31:0]   rx_data [8];
    n_iss = 0; n_rx = 0; bad = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (issue_ready && n_iss < 8) begin
        drive(1'b1, TW'(n_iss), 3'(n_iss), 32'h1000_0000 + n_iss, 8'(n_iss));
        n_iss++;
      end else idle();
      @(negedge clk);
    end
    idle();
    n_chk++; if (n_iss != DEP) $display("FAIL b2b_credit_count: got %0d want %0d", n_iss, DEP); else n_pass++;
    n_chk++; if (issue_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_tag !== 4'h0)
      $display("FAIL b2b_full: ready=%b valid=%b tag=%h want 0/1/0", issue_ready, rsp_valid, rsp_tag); else n_pass++;
    rsp_ready = 1'b1;
    for (int c = 0; c < 100 && n_rx < 8; c++) begin
      if (rsp_valid) begin
        rx_tag[n_rx]  = rsp_tag;
        rx_data[n_rx] = rsp_data;
        n_rx++;
      end
      if (issue_ready && n_iss < 8) begin
        drive(1'b1, TW'(n_iss), 3'(n_iss), 32'h1000_0000 + n_iss, 8'(n_iss));
        n_iss++;
      end else idle();
      @(negedge clk);
    end
    idle();
    n_chk++; if (n_rx != 8) $display("FAIL b2b_count: got %0d want 8", n_rx); else n_pass++;
    for (int j = 0; j < n_rx; j++)
      if (rx_tag[j] !== TW'(j) || rx_data[j] !== 32'h1000_0000 + j) bad++;
    n_chk++; if (bad != 0) $display("FAIL b2b_order: %0d entries wrong want 0", bad); else n_pass++;
    repeat (LAT + 2) @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b0 || err_drop !== 1'b0)
      $display("FAIL b2b_tail: valid=%b err_drop=%b want 0/0", rsp_valid, err_drop); else n_pass++;
  endtask

  task automatic test_stream();
    int n_iss, n_rx, bad;
    logic [TW-1:0] rx_tag [16];
    logic [31:0]   rx_data [16];
    n_iss = 0; n_rx = 0; bad = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, TW'(8 + n_iss), 3'd2, 32'h2000_0000 + n_iss, 8'h00);
      n_iss++;
      @(negedge clk);
    end
    idle();
    repeat (LAT) @(negedge clk);
    n_chk++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'h8)
      $display("FAIL stream_prefill: valid=%b tag=%h want 1/8", rsp_valid, rsp_tag); else n_pass++;
    rsp_ready = 1'b1;
    for (int c = 0; c < 200 && n_rx < 14; c++) begin
      if (rsp_valid) begin
        rx_tag[n_rx]  = rsp_tag;
        rx_data[n_rx] = rsp_data;
        n_rx++;
      end
      if (issue_ready && n_iss < 14) begin
        drive(1'b1, TW'(8 + n_iss), 3'd2, 32'h2000_0000 + n_iss, 8'h00);
        n_iss++;
      end else idle();
      @(negedge clk);
    end
    idle();
    n_chk++; if (n_rx != 14) $display("FAIL stream_count: got %0d want 14", n_rx); else n_pass++;
    for (int j = 0; j < n_rx; j++)
      if (rx_tag[j] !== TW'(8 + j) || rx_data[j] !== 32'h2000_0000 + j) bad++;
    n_chk++; if (bad != 0) $display("FAIL stream_wrap_data: %0d entries wrong want 0", bad); else n_pass++;
  endtask

  task automatic test_illegal();
    int n_iss, n_rx, bad;
    logic [TW-1:0] rx_tag [8];
    n_iss = 0; n_rx = 0; bad = 0;
    rsp_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (issue_ready && n_iss < 8) begin
        drive(1'b1, TW'(n_iss), 3'd1, 32'h3000_0000 + n_iss, 8'h00);
        n_iss++;
      end else idle();
      @(negedge clk);
    end
    n_chk++; if (issue_ready !== 1'b0 || err_drop !== 1'b0)
      $display("FAIL illegal_pre: ready=%b err_drop=%b want 0/0", issue_ready, err_drop); else n_pass++;
    drive(1'b1, 4'hA, 3'd7, 32'hBAD0_BAD0, 8'h00);
    @(negedge clk);
    idle();
    n_chk++; if (err_drop !== 1'b1) $display("FAIL illegal_err_set: got %b want 1", err_drop); else n_pass++;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid) begin
        if (n_rx < 8) rx_tag[n_rx] = rsp_tag;
        n_rx++;
      end
      @(negedge clk);
    end
    n_chk++; if (n_rx != 4) $display("FAIL illegal_resp_count: got %0d want 4", n_rx); else n_pass++;
    for (int j = 0; j < 4 && j < n_rx; j++)
      if (rx_tag[j] !== TW'(j)) bad++;
    n_chk++; if (bad != 0) $display("FAIL illegal_resp_tags: %0d wrong want 0", bad); else n_pass++;
    n_chk++; if (err_drop !== 1'b1) $display("FAIL illegal_err_sticky: got %b want 1", err_drop); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c, seen;
    rsp_ready = 1'b0;
    drive(1'b1, 4'h1, 3'd0, 32'h4000_0001, 8'h00);
    @(negedge clk);
    idle();
    c = 0;
    while (!rsp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    drive(1'b1, 4'h2, 3'd0, 32'h4000_0002, 8'h00);
    @(negedge clk);
    drive(1'b1, 4'h3, 3'd0, 32'h4000_0003, 8'h00);
    @(negedge clk);
    idle();
    n_chk++; if (rsp_valid !== 1'b1 || rsp_tag !== 4'h1)
      $display("FAIL rstmid_pre: valid=%b tag=%h want 1/1", rsp_valid, rsp_tag); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if (rsp_valid !== 1'b0 || issue_ready !== 1'b1 || err_drop !== 1'b0)
      $display("FAIL rstmid_ctrl: valid=%b ready=%b err=%b want 0/1/0", rsp_valid, issue_ready, err_drop); else n_pass++;
    n_chk++; if (rsp_data !== 32'h0 || rsp_tag !== 4'h0)
      $display("FAIL rstmid_data: data=%h tag=%h want 0/0", rsp_data, rsp_tag); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    n_chk++; if (seen != 0) $display("FAIL rstmid_ghost: %0d valid cycles want 0", seen); else n_pass++;
    drive(1'b1, 4'h6, 3'd1, 32'h3F00_0000, 8'h08);
    @(negedge clk);
    idle();
    c = 0;
    while (!rsp_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_chk++; if (c != LAT) $display("FAIL rstmid_new_latency: got %0d want %0d", c, LAT); else n_pass++;
    n_chk++; if (rsp_tag !== 4'h6 || rsp_data !== 32'h3F00_0000 || rsp_flags !== 8'h08)
      $display("FAIL rstmid_new_entry: tag=%h data=%h flags=%h want 6/3f000000/08", rsp_tag, rsp_data, rsp_flags); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single("add", 4'h3, 3'b000, 32'h4040_0000, 8'h00);
    test_single("div0", 4'h5, 3'b011, 32'h7F80_0000, 8'h81);
    test_back_to_back();
    test_stream();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
